// File: rtl/pp_pkg.sv
// Shared constants, FSM state type and parameter-derivation helpers for the
// sequential partial-product generator.
package pp_pkg;

   localparam logic PP_UNSIGNED = 1'b0;
   localparam logic PP_SIGNED   = 1'b1;

   typedef enum logic [0:0] {
      PP_IDLE = 1'b0,
      PP_EMIT = 1'b1
   } pp_state_e;

   function automatic int unsigned pp_clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (longint unsigned p = 1; p < longint'(v); p = p << 1) r++;
      return r;
   endfunction

   function automatic int unsigned pp_bw(input int unsigned w);
      return (pp_clog2(w) > 1) ? pp_clog2(w) : 1;
   endfunction

   function automatic int unsigned pp_nbeats(input int unsigned w, input int unsigned k);
      return w / k;
   endfunction

   function automatic bit pp_params_ok(input int unsigned w, input int unsigned k);
      return (w >= 2) && (k >= 1) && ((w % k) == 0);
   endfunction

endpackage

// File: rtl/pp_gen_seq_row.sv
// One partial-product row: shifted (sign/zero-extended) multiplicand, negated
// for the top row in signed mode so the row sum is the two's complement product.
module pp_row_gen
   import pp_pkg::*;
#(
   parameter  int unsigned WIDTH = 16,
   localparam int unsigned BW    = pp_bw(WIDTH),
   localparam int unsigned PW    = 2 * WIDTH
) (
   input  logic             a_bit,
   input  logic [WIDTH-1:0] b,
   input  logic [BW-1:0]    idx,
   input  logic             sgn,
   input  logic             is_msb_row,
   output logic [PW-1:0]    row
);

   logic [PW-1:0] ext_b;
   logic [PW-1:0] shifted;

   always_comb begin
      ext_b   = (sgn == PP_SIGNED) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
      shifted = ext_b << idx;
      row     = '0;
      if (a_bit) begin
         row = ((sgn == PP_SIGNED) && is_msb_row) ? (PW'(0) - shifted) : shifted;
      end
   end

endmodule

// File: rtl/pp_gen_seq.sv
// Sequential partial-product generator: captures an operand pair and streams
// its WIDTH rows out ROWS_PER_BEAT at a time over valid/ready.
module pp_gen_seq
   import pp_pkg::*;
#(
   parameter  int unsigned WIDTH         = 16,
   parameter  int unsigned ROWS_PER_BEAT = 4,
   localparam int unsigned BW            = pp_bw(WIDTH),
   localparam int unsigned PW            = 2 * WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_a,
   input  logic [WIDTH-1:0]            in_b,
   input  logic                        in_signed,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ROWS_PER_BEAT*PW-1:0] out_pp,
   output logic [BW-1:0]               out_row_base,
   output logic                        out_last
);

   localparam int unsigned NBEATS    = pp_nbeats(WIDTH, ROWS_PER_BEAT);
   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

   if (!pp_params_ok(WIDTH, ROWS_PER_BEAT)) begin : g_param_check
      $error("pp_gen_seq: WIDTH must be >= 2 and a multiple of ROWS_PER_BEAT");
   end

   pp_state_e        state_q, state_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sgn_q, sgn_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PP_IDLE;
         beat_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= PP_UNSIGNED;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
      end
   end

   // Next-state and handshake; a new operand may be taken on the final beat handshake.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      a_d       = a_q;
      b_d       = b_q;
      sgn_d     = sgn_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state_q)
         PP_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               sgn_d   = in_signed;
               beat_d  = '0;
               state_d = PP_EMIT;
            end
         end
         PP_EMIT: begin
            out_valid = 1'b1;
            out_last  = (beat_q == LAST_BEAT);
            if (out_ready) begin
               if (!out_last) begin
                  beat_d = beat_q + BW'(1);
               end else begin
                  in_ready = 1'b1;
                  beat_d   = '0;
                  if (in_valid) begin
                     a_d   = in_a;
                     b_d   = in_b;
                     sgn_d = in_signed;
                  end else begin
                     state_d = PP_IDLE;
                  end
               end
            end
         end
         default: state_d = PP_IDLE;
      endcase
   end

   assign out_row_base = BW'(32'(beat_q) * ROWS_PER_BEAT);

   for (genvar j = 0; j < ROWS_PER_BEAT; j++) begin : g_row
      logic [BW-1:0] idx;
      logic [PW-1:0] row;

      assign idx = out_row_base + BW'(j);

      pp_row_gen #(
         .WIDTH (WIDTH)
      ) u_row (
         .a_bit      (a_q[idx]),
         .b          (b_q),
         .idx        (idx),
         .sgn        (sgn_q),
         .is_msb_row (idx == BW'(WIDTH - 1)),
         .row        (row)
      );

      assign out_pp[j*PW +: PW] = (state_q == PP_EMIT) ? row : '0;
   end

endmodule

// File: tb/tb_pp_gen_seq.sv
// Randomised self-checking bench for pp_gen_seq (16x16 in 4 beats, 8x8 single beat).
module tb_pp_gen_seq;

   localparam int unsigned W1 = 16, K1 = 4, NB1 = 4;
   localparam int unsigned W2 = 8,  K2 = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         iv1, ir1, s1, ov1, or1, last1;
   logic [15:0]  a1, b1;
   logic [127:0] pp1;
   logic [3:0]   base1;

   logic         iv2, ir2, s2, ov2, or2, last2;
   logic [7:0]   a2, b2;
   logic [127:0] pp2;
   logic [2:0]   base2;

   int n_vec = 0;
   int n_err = 0;

   pp_gen_seq #(.WIDTH(W1), .ROWS_PER_BEAT(K1)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1),
      .in_signed(s1), .out_valid(ov1), .out_ready(or1), .out_pp(pp1),
      .out_row_base(base1), .out_last(last1));

   pp_gen_seq #(.WIDTH(W2), .ROWS_PER_BEAT(K2)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_a(a2), .in_b(b2),
      .in_signed(s2), .out_valid(ov2), .out_ready(or2), .out_pp(pp2),
      .out_row_base(base2), .out_last(last2));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic longint sval(input int w, input longint unsigned v, input bit s);
      if (s && (((v >> (w - 1)) & 1) == 1)) return longint'(v) - (longint'(1) << w);
      return longint'(v);
   endfunction

   function automatic longint unsigned mask2w(input int w, input longint v);
      return longint'(v) & ((longint'(1) << (2 * w)) - 1);
   endfunction

   // Row i of the multiplication a*b, straight from the row definition.
   function automatic longint unsigned ref_row(input int w, input longint unsigned a,
                                               input longint unsigned b, input bit s, input int i);
      longint v;
      if (((a >> i) & 1) == 0) return 0;
      v = sval(w, b, s) * (longint'(1) << i);
      if (s && (i == w - 1)) v = -v;
      return mask2w(w, v);
   endfunction

   function automatic longint unsigned ref_prod(input int w, input longint unsigned a,
                                                input longint unsigned b, input bit s);
      return mask2w(w, sval(w, a, s) * sval(w, b, s));
   endfunction

   task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s);
      @(negedge clk);
      iv1 = 1'b1; a1 = a; b1 = b; s1 = s; or1 = 1'($urandom);
      #1;
      check("idle_in_ready", 64'(ir1), 64'd1);
      check("idle_out_valid", 64'(ov1), 64'd0);
      check("idle_out_last", 64'(last1), 64'd0);
      @(posedge clk);
   endtask

   // Consume one 16-bit operation, optionally stalling, aborting via reset, or
   // chaining the next operand on the final beat handshake.
   task automatic recv16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input int stall_beat, input int stall_n, input int abort_beat,
                         input bit nv, input logic [15:0] na, input logic [15:0] nb,
                         input logic ns, output longint unsigned sum,
                         output longint unsigned top_row);
      longint unsigned r;
      sum = 0;
      top_row = 0;
      for (int bt = 0; bt < int'(NB1); bt++) begin
         for (int st = 0; st < ((bt == stall_beat) ? stall_n : 0); st++) begin
            @(negedge clk);
            or1 = 1'b0; iv1 = 1'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
            s1 = 1'($urandom);
            #1;
            check("stall_out_valid", 64'(ov1), 64'd1);
            check("stall_in_ready", 64'(ir1), 64'd0);
            check("stall_base", 64'(base1), 64'(bt * int'(K1)));
            for (int j = 0; j < int'(K1); j++)
               check("stall_row", 64'(pp1[j*32 +: 32]), ref_row(16, a, b, s, bt * int'(K1) + j));
         end
         @(negedge clk);
         if (bt == abort_beat) begin
            rst = 1'b1; iv1 = 1'b0; or1 = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("rst_out_valid", 64'(ov1), 64'd0);
            check("rst_out_last", 64'(last1), 64'd0);
            check("rst_in_ready", 64'(ir1), 64'd1);
            check("rst_pp_lo", pp1[63:0], 64'd0);
            check("rst_pp_hi", pp1[127:64], 64'd0);
            check("rst_base", 64'(base1), 64'd0);
            return;
         end
         or1 = 1'b1;
         if (bt == int'(NB1) - 1) begin
            iv1 = nv; a1 = na; b1 = nb; s1 = ns;
         end else begin
            iv1 = 1'($urandom); a1 = 16'($urandom); b1 = 16'($urandom); s1 = 1'($urandom);
         end
         #1;
         check("out_valid", 64'(ov1), 64'd1);
         check("out_row_base", 64'(base1), 64'(bt * int'(K1)));
         check("out_last", 64'(last1), 64'(bt == int'(NB1) - 1));
         check("in_ready", 64'(ir1), 64'(bt == int'(NB1) - 1));
         for (int j = 0; j < int'(K1); j++) begin
            r = ref_row(16, a, b, s, bt * int'(K1) + j);
            check("row", 64'(pp1[j*32 +: 32]), r);
            sum = sum + 64'(pp1[j*32 +: 32]);
            if (bt * int'(K1) + j == 15) top_row = 64'(pp1[j*32 +: 32]);
         end
         @(posedge clk);
      end
      sum = sum & 64'hFFFF_FFFF;
      check("row_sum", sum, ref_prod(16, a, b, s));
   endtask

   initial begin
      longint unsigned sum, top;
      logic [15:0] ca, cb, na, nb;
      logic cs, ns;
      bit nv, pending;
      logic [7:0] pa, pb;
      logic ps;
      bit have;
      longint unsigned sum8;

      rst = 1'b1;
      iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0;
      iv2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0; s2 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_in_ready", 64'(ir1), 64'd1);
      check("reset_out_valid", 64'(ov1), 64'd0);
      check("reset_out_last", 64'(last1), 64'd0);
      check("reset_pp_lo", pp1[63:0], 64'd0);
      check("reset_pp_hi", pp1[127:64], 64'd0);
      check("reset_base", 64'(base1), 64'd0);
      check("reset8_in_ready", 64'(ir2), 64'd1);
      check("reset8_out_valid", 64'(ov2), 64'd0);

      // Signed -1 * 3
      send16(16'hFFFF, 16'h0003, 1'b1);
      recv16(16'hFFFF, 16'h0003, 1'b1, -1, 0, -1, 1'b0, '0, '0, 1'b0, sum, top);
      check("t1_sum", sum, 64'hFFFF_FFFD);

      // Unsigned max * max: top row is not negated
      send16(16'hFFFF, 16'hFFFF, 1'b0);
      recv16(16'hFFFF, 16'hFFFF, 1'b0, -1, 0, -1, 1'b0, '0, '0, 1'b0, sum, top);
      check("t2_row15", top, 64'h7FFF_8000);
      check("t2_sum", sum, 64'hFFFE_0001);

      // Signed most-negative squared
      send16(16'h8000, 16'h8000, 1'b1);
      recv16(16'h8000, 16'h8000, 1'b1, -1, 0, -1, 1'b0, '0, '0, 1'b0, sum, top);
      check("t3_row15", top, 64'h4000_0000);
      check("t3_sum", sum, 64'h4000_0000);

      // a = 0 still yields all beats of zero rows
      cb = 16'($urandom);
      send16(16'h0000, cb, 1'b1);
      recv16(16'h0000, cb, 1'b1, -1, 0, -1, 1'b0, '0, '0, 1'b0, sum, top);
      check("t_zero_sum", sum, 64'd0);

      // Backpressure on beat 1, then chained operand with no bubble
      ca = 16'($urandom); cb = 16'($urandom);
      na = 16'($urandom); nb = 16'($urandom);
      send16(ca, cb, 1'b1);
      recv16(ca, cb, 1'b1, 1, 3, -1, 1'b1, na, nb, 1'b0, sum, top);
      recv16(na, nb, 1'b0, -1, 0, -1, 1'b0, '0, '0, 1'b0, sum, top);

      // Reset during beat 2, then a fresh operation
      ca = 16'($urandom); cb = 16'($urandom);
      send16(ca, cb, 1'b0);
      recv16(ca, cb, 1'b0, -1, 0, 2, 1'b0, '0, '0, 1'b0, sum, top);
      ca = 16'($urandom); cb = 16'($urandom);
      send16(ca, cb, 1'b1);
      recv16(ca, cb, 1'b1, -1, 0, -1, 1'b0, '0, '0, 1'b0, sum, top);

      // Random operations with random stalls and chaining
      pending = 1'b0;
      ca = 16'($urandom); cb = 16'($urandom); cs = 1'($urandom);
      for (int it = 0; it < 40; it++) begin
         na = 16'($urandom); nb = 16'($urandom); ns = 1'($urandom);
         nv = (it < 39) ? 1'($urandom) : 1'b0;
         if (!pending) send16(ca, cb, cs);
         recv16(ca, cb, cs, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1,
                nv, na, nb, ns, sum, top);
         ca = na; cb = nb; cs = ns; pending = nv;
      end

      // 8x8 single-beat streaming, signed then unsigned
      have = 1'b0;
      pa = '0; pb = '0; ps = 1'b0;
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            or2 = 1'b1; iv2 = 1'b1;
            a2 = 8'($urandom); b2 = 8'($urandom); s2 = (m == 0);
            #1;
            check("s8_in_ready", 64'(ir2), 64'd1);
            if (have) begin
               check("s8_out_valid", 64'(ov2), 64'd1);
               check("s8_out_last", 64'(last2), 64'd1);
               check("s8_base", 64'(base2), 64'd0);
               sum8 = 0;
               for (int j = 0; j < int'(K2); j++) begin
                  check("s8_row", 64'(pp2[j*16 +: 16]), ref_row(8, pa, pb, ps, j));
                  sum8 = sum8 + 64'(pp2[j*16 +: 16]);
               end
               check("s8_sum", sum8 & 64'hFFFF, ref_prod(8, pa, pb, ps));
            end
            pa = a2; pb = b2; ps = s2; have = 1'b1;
         end
      end
      @(negedge clk);
      iv2 = 1'b0;
      #1;
      check("s8_tail_valid", 64'(ov2), 64'd1);
      sum8 = 0;
      for (int j = 0; j < int'(K2); j++) sum8 = sum8 + 64'(pp2[j*16 +: 16]);
      check("s8_tail_sum", sum8 & 64'hFFFF, ref_prod(8, pa, pb, ps));
      @(negedge clk);
      #1;
      check("s8_drain_valid", 64'(ov2), 64'd0);
      check("s8_drain_in_ready", 64'(ir2), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
